// File: rtl/frame_flusher_pkg.sv
// Shared types and defaults for the frame flusher block.
// Holds the FSM state type, the 6-bit colour type, the 8-bit coordinate type
// and the default screen geometry used by the top level.
package frame_flusher_pkg;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int COLOUR_W     = 6;
   localparam int COORD_W      = 8;

   typedef logic [COLOUR_W-1:0] colour_t;
   typedef logic [COORD_W-1:0]  coord_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/frame_flusher_if.sv
// Bundle of control, layer-sample and pixel-output signals of the frame flusher.
// master: the flusher (consumes start/stall/layer inputs, drives coordinates and pixels).
// slave : the surrounding system (layer decoders, framebuffer writer, controller).
interface frame_flusher_if
   import frame_flusher_pkg::*;
#(
   parameter int N_LAYERS = 4
);
   logic                     start;
   logic                     stall;
   logic [N_LAYERS-1:0]      layer_en;
   logic [6*N_LAYERS-1:0]    layer_colour;
   coord_t                   flush_x;
   coord_t                   flush_y;
   coord_t                   vga_x;
   coord_t                   vga_y;
   colour_t                  vga_colour;
   logic                     vga_plot;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, stall, layer_en, layer_colour,
      output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   modport slave (
      output start, stall, layer_en, layer_colour,
      input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );
endinterface

// File: rtl/frame_flusher_layer_priority_mux.sv
// Purpose: resolve one pixel colour from N_LAYERS enable/colour pairs, lowest index wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: en_i (per-layer enable), colour_i (layer i at [6i+5:6i]), colour_o (resolved colour).
module layer_priority_mux
   import frame_flusher_pkg::*;
#(
   parameter int      N_LAYERS  = 4,
   parameter colour_t BG_COLOUR = 6'b000000
) (
   input  logic [N_LAYERS-1:0]   en_i,
   input  logic [6*N_LAYERS-1:0] colour_i,
   output colour_t               colour_o
);

   // Walk from the lowest-priority layer upward so the last hit (lowest
   // index) overwrites any earlier one.
   always_comb begin
      colour_o = BG_COLOUR;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (en_i[i]) begin
            colour_o = colour_i[6*i +: 6];
         end
      end
   end

endmodule

// File: rtl/frame_flusher.sv
// Purpose: raster-scan one frame, resolve layered colour per pixel, stream plots out.
// Latency: pixel appears on vga_* one cycle after its coordinate is issued on flush_*.
// Backpressure: stall high freezes counters, pixel registers, vga_plot and FSM.
// Ports: clk, resetn (sync, active-low); ff (master modport): start/stall/layer_en/
//        layer_colour in, flush_x/flush_y/vga_x/vga_y/vga_colour/vga_plot/busy/done out.
// Build option: FLUSH_SKIP_BG_EN suppresses plots for pixels resolving to BG_COLOUR.
module frame_flusher
   import frame_flusher_pkg::*;
#(
   parameter int      N_LAYERS  = 4,
   parameter int      SCREEN_W  = SCREEN_W_DEF,
   parameter int      SCREEN_H  = SCREEN_H_DEF,
   parameter colour_t BG_COLOUR = 6'b000000
) (
   input  logic              clk,
   input  logic              resetn,
   frame_flusher_if.master   ff
);

   localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
   localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

   state_t  state_q, state_d;
   coord_t  fx_q, fx_d;
   coord_t  fy_q, fy_d;
   coord_t  vx_q, vx_d;
   coord_t  vy_q, vy_d;
   colour_t vc_q, vc_d;
   logic    vp_q, vp_d;
   logic    busy_q, busy_d;
   logic    done_q, done_d;

   colour_t pix_colour;
   logic    plot_en;

   layer_priority_mux #(
      .N_LAYERS  (N_LAYERS),
      .BG_COLOUR (BG_COLOUR)
   ) u_mux (
      .en_i     (ff.layer_en),
      .colour_i (ff.layer_colour),
      .colour_o (pix_colour)
   );

`ifdef FLUSH_SKIP_BG_EN
   // Background pixels leave the framebuffer untouched; scan timing is unchanged.
   assign plot_en = (pix_colour != BG_COLOUR);
`else
   assign plot_en = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         fx_q    <= '0;
         fy_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vc_q    <= '0;
         vp_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vc_q    <= vc_d;
         vp_q    <= vp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vc_d    = vc_q;
      vp_d    = vp_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // done is still high in the first IDLE cycle; a start there is
            // deliberately dropped so a frame cannot chain off its own done.
            if (ff.start && !done_q) begin
               state_d = ST_SCAN;
               fx_d    = '0;
               fy_d    = '0;
               busy_d  = 1'b1;
            end
         end

         ST_SCAN: begin
            if (!ff.stall) begin
               vx_d = fx_q;
               vy_d = fy_q;
               vc_d = pix_colour;
               vp_d = plot_en;
               if (fx_q == X_LAST) begin
                  if (fy_q == Y_LAST) begin
                     // Last coordinate: counters park here rather than overflow.
                     state_d = ST_DRAIN;
                  end else begin
                     fx_d = '0;
                     fy_d = fy_q + 8'd1;
                  end
               end else begin
                  fx_d = fx_q + 8'd1;
               end
            end
         end

         ST_DRAIN: begin
            // Last pixel is on the outputs; retire it on the first unstalled cycle.
            if (!ff.stall) begin
               vp_d    = 1'b0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ff.flush_x    = fx_q;
   assign ff.flush_y    = fy_q;
   assign ff.vga_x      = vx_q;
   assign ff.vga_y      = vy_q;
   assign ff.vga_colour = vc_q;
   assign ff.vga_plot   = vp_q;
   assign ff.busy       = busy_q;
   assign ff.done       = done_q;

endmodule

// File: tb/tb_frame_flusher.sv
// Randomized bench for frame_flusher: layer decoders are modelled as pure
// functions of the scan coordinate, and every accepted plot is compared with
// the raster-order pixel list computed from the priority rule.
module tb_frame_flusher;
   import frame_flusher_pkg::*;

   localparam int      N  = 4;
   localparam int      W  = 160;
   localparam int      H  = 120;
   localparam colour_t BG = 6'h00;

   logic clk;
   logic resetn;
   int   lmode;
   int   n_chk;
   int   n_pass;
   int   exp_idx;
   int   plots;

   frame_flusher_if #(.N_LAYERS(N)) ifc ();

   frame_flusher #(
      .N_LAYERS  (N),
      .SCREEN_W  (W),
      .SCREEN_H  (H),
      .BG_COLOUR (BG)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .ff     (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- layer decoder model ----------------
   function automatic logic [31:0] mix(input int a, input int b);
      logic [31:0] h;
      h = (32'(a) * 32'd131 + 32'(b) * 32'd7919 + 32'h9E37) * 32'h2545F491;
      return h ^ (h >> 15);
   endfunction

   // mode 0: nothing enabled; mode 1: only the two directed points;
   // mode 2: hashed random layers plus the directed points.
   function automatic logic [N-1:0] lay_en(input logic [7:0] x, input logic [7:0] y, input int m);
      logic [N-1:0] e;
      logic [31:0]  h;
      h = mix(int'(x), int'(y));
      e = (m == 2) ? h[N-1:0] : '0;
      if (m != 0 && x == 8'd5  && y == 8'd7)  e = 4'b0010;
      if (m != 0 && x == 8'd10 && y == 8'd10) e = 4'b0101;
      return e;
   endfunction

   function automatic logic [6*N-1:0] lay_col(input logic [7:0] x, input logic [7:0] y, input int m);
      logic [6*N-1:0] c;
      logic [63:0]    hh;
      hh = {mix(int'(x), int'(y)), mix(int'(y) + 3, int'(x) + 11)};
      c  = (m == 1) ? '0 : hh[4 +: 6*N];
      if (m != 0 && x == 8'd5 && y == 8'd7) c[6 +: 6] = 6'h2A;
      if (m != 0 && x == 8'd10 && y == 8'd10) begin
         c[0  +: 6] = 6'h01;
         c[12 +: 6] = 6'h3F;
      end
      return c;
   endfunction

   assign ifc.layer_en     = lay_en(ifc.flush_x, ifc.flush_y, lmode);
   assign ifc.layer_colour = lay_col(ifc.flush_x, ifc.flush_y, lmode);

   // Reference colour: first enabled layer in priority order, else background.
   function automatic colour_t ref_colour(input int x, input int y, input int m);
      logic [N-1:0]   e;
      logic [6*N-1:0] c;
      colour_t        r;
      bit             found;
      e = lay_en(8'(x), 8'(y), m);
      c = lay_col(8'(x), 8'(y), m);
      r = BG;
      found = 0;
      for (int i = 0; i < N; i++) begin
         if (e[i] && !found) begin
            r = c[6*i +: 6];
            found = 1;
         end
      end
      return r;
   endfunction

   function automatic int expected_plots(input int m);
      int n;
      n = 0;
      for (int p = 0; p < W*H; p++) begin
`ifdef FLUSH_SKIP_BG_EN
         if (ref_colour(p % W, p / W, m) != BG) n++;
`else
         n++;
`endif
      end
      return n;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
   endtask

   // Called at the negedge when vga_plot is high and stall is low: one accepted pixel.
   task automatic consume();
      int x;
      int y;
`ifdef FLUSH_SKIP_BG_EN
      while (exp_idx < W*H && ref_colour(exp_idx % W, exp_idx / W, lmode) == BG) exp_idx++;
`endif
      x = exp_idx % W;
      y = exp_idx / W;
      chk("plot_x", int'(ifc.vga_x), x);
      chk("plot_y", int'(ifc.vga_y), y);
      chk("plot_colour", int'(ifc.vga_colour), int'(ref_colour(x, y, lmode)));
      if (x == 5 && y == 7)   chk("pix_5_7", int'(ifc.vga_colour), 'h2A * int'(lmode != 0));
      if (x == 10 && y == 10 && lmode != 0) chk("pix_10_10", int'(ifc.vga_colour), 'h01);
      exp_idx++;
      plots++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flush_x"}, int'(ifc.flush_x), 0);
      chk({tag, "_flush_y"}, int'(ifc.flush_y), 0);
      chk({tag, "_vga_x"}, int'(ifc.vga_x), 0);
      chk({tag, "_vga_y"}, int'(ifc.vga_y), 0);
      chk({tag, "_vga_colour"}, int'(ifc.vga_colour), 0);
      chk({tag, "_vga_plot"}, int'(ifc.vga_plot), 0);
      chk({tag, "_busy"}, int'(ifc.busy), 0);
      chk({tag, "_done"}, int'(ifc.done), 0);
   endtask

   // One full frame. Entered and left #1 after a posedge.
   task automatic run_frame(input int m, input int stall_pct, input bit burst,
                            input bit chk_timing, input bit start_on_done);
      int edges;
      int bp;
      bit seen_done;
      lmode   = m;
      exp_idx = 0;
      plots   = 0;
      bp      = 0;
      seen_done = 0;
      ifc.stall = 1'b0;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      edges = 0;
      chk("start_busy", int'(ifc.busy), 1);
      chk("start_flush_x", int'(ifc.flush_x), 0);
      chk("start_flush_y", int'(ifc.flush_y), 0);
      while (edges < 40000) begin
         if (ifc.done) begin
            seen_done = 1;
            break;
         end
         chk("busy_in_frame", int'(ifc.busy), 1);
         ifc.stall = ($urandom_range(99) < stall_pct);
         ifc.start = (burst && edges == 5000);
         if (burst && bp == 0 && ifc.flush_x == 8'd159 && ifc.flush_y == 8'd0) bp = 1;
         if (bp >= 1 && bp <= 3) begin
            chk("burst_hold_x", int'(ifc.flush_x), 159);
            chk("burst_hold_y", int'(ifc.flush_y), 0);
            ifc.stall = 1'b1;
            bp++;
         end else if (bp == 4) begin
            chk("burst_hold_x", int'(ifc.flush_x), 159);
            ifc.stall = 1'b0;
            bp = 5;
         end else if (bp == 5) begin
            chk("wrap_x", int'(ifc.flush_x), 0);
            chk("wrap_y", int'(ifc.flush_y), 1);
            bp = 6;
         end
         @(negedge clk);
         if (ifc.vga_plot && !ifc.stall) consume();
         @(posedge clk);
         edges++;
         #1;
      end
      ifc.stall = 1'b0;
      chk("done_seen", int'(seen_done), 1);
      if (chk_timing) chk("done_cycle", edges, 19202);
      if (burst) chk("burst_visited", bp, 6);
      chk("plot_count", plots, expected_plots(m));
      chk("busy_at_done", int'(ifc.busy), 0);
      ifc.start = start_on_done;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      chk("done_pulse_width", int'(ifc.done), 0);
      chk("idle_after_done", int'(ifc.busy), 0);
   endtask

   initial begin
      int guard;
      n_chk  = 0;
      n_pass = 0;
      lmode  = 0;
      exp_idx = 0;
      plots  = 0;
      resetn = 1'b0;
      ifc.start = 1'b0;
      ifc.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Background-only frame, no stall, exact completion timing; start
      // raised together with done must not relaunch.
      run_frame(0, 0, 1'b0, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("no_relaunch_busy", int'(ifc.busy), 0);

      // Random layers, random stall, a 3-cycle stall at the row wrap, and a
      // stray start mid-frame.
      run_frame(2, 10, 1'b1, 1'b0, 1'b0);

      // Abort mid-frame with reset at (80,60).
      lmode   = 2;
      exp_idx = 0;
      plots   = 0;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      guard = 0;
      while (!(ifc.flush_x == 8'd80 && ifc.flush_y == 8'd60) && guard < 20000) begin
         @(negedge clk);
         if (ifc.vga_plot && !ifc.stall) consume();
         @(posedge clk);
         guard++;
         #1;
      end
      chk("reach_80_60", int'(guard < 20000), 1);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk_all_zero("abort");
      resetn = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_reset_busy", int'(ifc.busy), 0);
      chk("post_reset_plot", int'(ifc.vga_plot), 0);
      chk("post_reset_flush_x", int'(ifc.flush_x), 0);

      // Fresh start after the abort: directed-only layers, scan from (0,0).
      run_frame(1, 0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
